// File: rtl/mm2str.sv
// Memory-mapped to stream playback: CPU fills a sample buffer, programs LEN,
// then starts; samples leave as one AXI4-stream packet with tlast on the final beat.
module mm2str #(
  parameter int DW = 14,
  parameter int DL = 256,
  parameter int LW = $clog2(DL) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   bus_addr,
  input  logic [31:0]   bus_wdata,
  input  logic          bus_wen,
  input  logic          bus_ren,
  output logic [31:0]   bus_rdata,
  output logic          bus_ack,
  output logic          bus_err,
  output logic [DW-1:0] str_tdata,
  output logic          str_tlast,
  output logic          str_tvalid,
  input  logic          str_tready
);
  localparam int AW = $clog2(DL);
  localparam int A  = AW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_next;

  logic [DW-1:0] mem [DL];
  logic [DW-1:0] a_q, b_q;
  logic [LW-1:0] len_q, fetch, idx;
  logic          aborted, rvld, rlast;
  logic          out_valid, out_last, sk_valid, sk_last;
  logic [DW-1:0] out_data, sk_data;
  logic          rd_buf_q;
  logic [31:0]   rd_reg_q;

  logic          sel_reg, busy, is_ctl, is_len, is_sts, bad_off;
  logic          start_req, stop_req, buf_we, len_we, acc_err;
  logic          pop, issue, push;
  logic [1:0]    inflight;
  logic [AW-1:0] word;
  logic [A-1:0]  off;
  logic [LW-1:0] len_wr_val;
  logic [31:0]   reg_rdata;

  assign sel_reg   = bus_addr[A];
  assign word      = bus_addr[AW+1:2];
  assign off       = bus_addr[A-1:0];
  assign busy      = (state != IDLE);
  assign is_ctl    = sel_reg && (off == A'(0));
  assign is_len    = sel_reg && (off == A'(4));
  assign is_sts    = sel_reg && (off == A'(8));
  assign bad_off   = sel_reg && !(is_ctl || is_len || is_sts);
  assign start_req = bus_wen && is_ctl && bus_wdata[0];
  assign stop_req  = bus_wen && is_ctl && bus_wdata[1];
  assign buf_we    = bus_wen && !sel_reg && !busy;
  assign len_we    = bus_wen && is_len && !busy;
  assign acc_err   = bad_off || (bus_wen && busy && (!sel_reg || is_len));
  assign len_wr_val = (bus_wdata > 32'(DL)) ? LW'(DL) : bus_wdata[LW-1:0];

  // Credit check: a read issued now lands next cycle, so entries held plus the
  // one in flight, minus this cycle's handshake, must leave room in the skid.
  assign pop      = out_valid && str_tready;
  assign inflight = 2'(out_valid) + 2'(sk_valid) + 2'(rvld);
  assign issue    = (state == RUN) && (fetch < len_q) && (inflight <= 2'(pop) + 2'd1);
  assign push     = rvld && (state_next == RUN);

  always_comb begin
    reg_rdata = '0;
    if (is_len)
      reg_rdata = 32'(len_q);
    else if (is_sts)
      reg_rdata = (32'(idx) << 16) | {30'b0, aborted, busy};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_req && len_q != '0) state_next = RUN;
      RUN: begin
        if (pop && out_last)
          state_next = IDLE;
        else if (stop_req)
          state_next = (out_valid && !pop) ? DRAIN : IDLE;
      end
      DRAIN:   if (pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Dual-port buffer: port A for the bus, port B for playback, both registered reads.
  always_ff @(posedge clk) begin
    if (buf_we) mem[word] <= bus_wdata[DW-1:0];
    a_q <= mem[word];
    b_q <= mem[fetch[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ack  <= 1'b0;
      bus_err  <= 1'b0;
      rd_buf_q <= 1'b0;
      rd_reg_q <= '0;
      len_q    <= LW'(DL);
    end else begin
      bus_ack  <= bus_wen || bus_ren;
      bus_err  <= (bus_wen || bus_ren) && acc_err;
      rd_buf_q <= bus_ren && !sel_reg;
      rd_reg_q <= (bus_ren && sel_reg) ? reg_rdata : '0;
      if (len_we) len_q <= len_wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch     <= '0;
      idx       <= '0;
      aborted   <= 1'b0;
      rvld      <= 1'b0;
      rlast     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      sk_valid  <= 1'b0;
      sk_last   <= 1'b0;
      sk_data   <= '0;
    end else begin
      rvld  <= issue && (state_next == RUN);
      rlast <= (fetch == len_q - LW'(1));
      if (state == IDLE && state_next == RUN) begin
        fetch   <= '0;
        idx     <= '0;
        aborted <= 1'b0;
      end else begin
        if (issue) fetch <= fetch + LW'(1);
        if (pop)   idx   <= idx + LW'(1);
      end
      if (state == RUN && state_next == IDLE && !(pop && out_last))
        aborted <= 1'b1;
      else if (state == DRAIN && state_next == IDLE)
        aborted <= !out_last;

      // Leaving RUN flushes everything except a beat already on the wire.
      if (state_next != RUN) begin
        sk_valid  <= 1'b0;
        out_valid <= out_valid && !pop;
      end else if (!out_valid || pop) begin
        if (sk_valid) begin
          out_valid <= 1'b1;
          out_data  <= sk_data;
          out_last  <= sk_last;
          sk_valid  <= push;
          if (push) begin
            sk_data <= b_q;
            sk_last <= rlast;
          end
        end else begin
          out_valid <= push;
          if (push) begin
            out_data <= b_q;
            out_last <= rlast;
          end
        end
      end else if (push) begin
        sk_valid <= 1'b1;
        sk_data  <= b_q;
        sk_last  <= rlast;
      end
    end
  end

  assign bus_rdata  = rd_buf_q ? {{(32-DW){a_q[DW-1]}}, a_q} : rd_reg_q;
  assign str_tdata  = out_data;
  assign str_tvalid = out_valid;
  assign str_tlast  = out_valid && out_last;

endmodule

// File: tb/tb_mm2str.sv
// Directed bench for mm2str: table-driven bus accesses plus packet, stall,
// stop and reset sequences with a negedge stream monitor.
module tb_mm2str;
  localparam int DW = 14;
  localparam int DL = 256;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic          bus_wen = 1'b0;
  logic          bus_ren = 1'b0;
  logic [31:0]   bus_rdata;
  logic          bus_ack;
  logic          bus_err;
  logic [DW-1:0] str_tdata;
  logic          str_tlast;
  logic          str_tvalid;
  logic          str_tready;

  mm2str #(.DW(DW), .DL(DL), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen), .bus_ren(bus_ren),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .str_tdata(str_tdata), .str_tlast(str_tlast), .str_tvalid(str_tvalid),
    .str_tready(str_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_op_cyc = 0;
  logic ready_val = 1'b1;
  logic rnd_mode = 1'b0;
  logic [7:0] lfsr = 8'h5A;

  logic [DW-1:0] beat_data[$];
  logic          beat_last[$];
  int            beat_cyc[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  assign str_tready = rnd_mode ? lfsr[0] : ready_val;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Stream monitor: records handshakes and checks that a stalled beat stays put.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(str_tvalid), 32'd1);
        checkOutput("hold_data", 32'(str_tdata), 32'(prev_data));
        checkOutput("hold_last", 32'(str_tlast), 32'(prev_last));
      end
      if (str_tvalid && str_tready) begin
        beat_data.push_back(str_tdata);
        beat_last.push_back(str_tlast);
        beat_cyc.push_back(cyc);
      end
      prev_stall = str_tvalid && !str_tready;
      prev_data  = str_tdata;
      prev_last  = str_tlast;
    end
  end

  task automatic busOp(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output logic ack);
    @(posedge clk); #1;
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_wen   = wr;
    bus_ren   = !wr;
    last_op_cyc = cyc;
    @(posedge clk); #1;
    bus_wen = 1'b0;
    bus_ren = 1'b0;
    @(negedge clk);
    ack   = bus_ack;
    err   = bus_err;
    rdata = bus_rdata;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] rd;
    logic        er, ak;
    busOp(v.wr, v.addr, v.wdata, rd, er, ak);
    checkOutput($sformatf("ack_%s_%03h", v.wr ? "wr" : "rd", v.addr), 32'(ak), 32'd1);
    checkOutput($sformatf("err_%s_%03h", v.wr ? "wr" : "rd", v.addr), 32'(er), 32'(v.exp_err));
    if (!v.wr)
      checkOutput($sformatf("rdata_%03h", v.addr), rd, v.exp_rdata);
  endtask

  task automatic waitBeats(input int n, input int limit);
    int k = 0;
    while (beat_data.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic checkPacket(input string tag, input logic check_timing, input int t0);
    checkOutput({tag, "_count"}, 32'(beat_data.size()), 32'd16);
    for (int k = 0; k < 16 && k < beat_data.size(); k++) begin
      logic [DW-1:0] exp_d;
      exp_d = DW'(k - 8);
      checkOutput($sformatf("%s_data%0d", tag, k), 32'(beat_data[k]), 32'(exp_d));
      checkOutput($sformatf("%s_last%0d", tag, k), 32'(beat_last[k]), 32'(k == 15));
      if (check_timing)
        checkOutput($sformatf("%s_cyc%0d", tag, k), 32'(beat_cyc[k]), 32'(t0 + 3 + k));
    end
  endtask

  initial begin
    vec_t vecs[$];
    vec_t run_vecs[$];
    int   t0;
    int   nlast;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_tvalid", 32'(str_tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(str_tlast), 32'd0);
    checkOutput("rst_tdata", 32'(str_tdata), 32'd0);
    checkOutput("rst_ack", 32'(bus_ack), 32'd0);
    checkOutput("rst_err", 32'(bus_err), 32'd0);
    checkOutput("rst_rdata", bus_rdata, 32'd0);

    vecs.push_back('{1'b0, 32'h408, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h404, 32'h0, 32'h0000_0100, 1'b0});
    vecs.push_back('{1'b1, 32'h404, 32'd300, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h404, 32'h0, 32'h0000_0100, 1'b0});
    vecs.push_back('{1'b1, 32'h404, 32'd0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h404, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h400, 32'h1, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h408, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h40C, 32'h5, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h40C, 32'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h400, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h050, 32'hABCD_2001, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h050, 32'h0, 32'hFFFF_E001, 1'b0});
    for (int k = 0; k < 16; k++)
      vecs.push_back('{1'b1, 32'(k * 4), 32'(k - 8), 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h00C, 32'h0, 32'hFFFF_FFFB, 1'b0});
    vecs.push_back('{1'b0, 32'h03C, 32'h0, 32'h0000_0007, 1'b0});
    vecs.push_back('{1'b1, 32'h404, 32'd16, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h404, 32'h0, 32'h0000_0010, 1'b0});

    foreach (vecs[i]) applyStimulus(vecs[i]);
    checkOutput("len0_no_beats", 32'(beat_data.size()), 32'd0);

    $display("[TB] packet with tready held high");
    ready_val = 1'b1;
    applyStimulus('{1'b1, 32'h400, 32'h1, 32'h0, 1'b0});
    t0 = last_op_cyc;
    applyStimulus('{1'b0, 32'h408, 32'h0, 32'h0000_0001, 1'b0});
    waitBeats(16, 100);
    repeat (3) @(negedge clk);
    checkPacket("pkt1", 1'b1, t0);
    applyStimulus('{1'b0, 32'h408, 32'h0, 32'h0010_0000, 1'b0});

    $display("[TB] packet with pseudo-random tready");
    beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    rnd_mode = 1'b1;
    applyStimulus('{1'b1, 32'h400, 32'h1, 32'h0, 1'b0});
    waitBeats(16, 400);
    repeat (6) @(negedge clk);
    rnd_mode = 1'b0;
    checkPacket("pkt2", 1'b0, 0);
    applyStimulus('{1'b0, 32'h408, 32'h0, 32'h0010_0000, 1'b0});

    $display("[TB] stop with a stalled beat pending");
    beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    ready_val = 1'b0;
    applyStimulus('{1'b1, 32'h400, 32'h1, 32'h0, 1'b0});
    t0 = last_op_cyc;
    while (cyc < t0 + 3) begin @(posedge clk); #1; end
    ready_val = 1'b1;
    while (cyc < t0 + 8) begin @(posedge clk); #1; end
    ready_val = 1'b0;
    run_vecs.push_back('{1'b1, 32'h00C, 32'd100, 32'h0, 1'b1});
    run_vecs.push_back('{1'b0, 32'h00C, 32'h0, 32'hFFFF_FFFB, 1'b0});
    run_vecs.push_back('{1'b1, 32'h404, 32'd5, 32'h0, 1'b1});
    run_vecs.push_back('{1'b1, 32'h40C, 32'h1, 32'h0, 1'b1});
    run_vecs.push_back('{1'b1, 32'h400, 32'h1, 32'h0, 1'b0});
    run_vecs.push_back('{1'b0, 32'h408, 32'h0, 32'h0005_0001, 1'b0});
    run_vecs.push_back('{1'b1, 32'h400, 32'h2, 32'h0, 1'b0});
    foreach (run_vecs[i]) applyStimulus(run_vecs[i]);
    repeat (4) @(negedge clk);
    checkOutput("stop_held_valid", 32'(str_tvalid), 32'd1);
    checkOutput("stop_held_data", 32'(str_tdata), 32'(14'h3FFD));
    checkOutput("stop_held_count", 32'(beat_data.size()), 32'd5);
    @(posedge clk); #1;
    ready_val = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("stop_count", 32'(beat_data.size()), 32'd6);
    if (beat_data.size() == 6)
      checkOutput("stop_last_data", 32'(beat_data[5]), 32'(14'h3FFD));
    nlast = 0;
    foreach (beat_last[i]) if (beat_last[i]) nlast++;
    checkOutput("stop_no_tlast", 32'(nlast), 32'd0);
    applyStimulus('{1'b0, 32'h408, 32'h0, 32'h0006_0002, 1'b0});
    applyStimulus('{1'b0, 32'h404, 32'h0, 32'h0000_0010, 1'b0});
    applyStimulus('{1'b0, 32'h00C, 32'h0, 32'hFFFF_FFFB, 1'b0});

    $display("[TB] reset in the middle of a packet");
    beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    applyStimulus('{1'b1, 32'h400, 32'h1, 32'h0, 1'b0});
    t0 = last_op_cyc;
    while (cyc < t0 + 6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_tvalid", 32'(str_tvalid), 32'd0);
    checkOutput("midrst_tlast", 32'(str_tlast), 32'd0);
    applyStimulus('{1'b0, 32'h408, 32'h0, 32'h0000_0000, 1'b0});
    applyStimulus('{1'b0, 32'h404, 32'h0, 32'h0000_0100, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mm2str.md
# mm2str

Memory-mapped to stream playback block, the transmit-side counterpart of `str2mm`. The CPU fills a sample buffer over the system bus, programs a length, and starts playback. The block then emits the samples as a single AXI4-stream packet with `tlast` on the final sample. It sits between the `sys_bus` interconnect and a generator/DAC stream path.

## Interface
- `DW`, 14: sample width; samples are signed and stored as `DW` bits.
- `DL`, 256: buffer depth in samples; must be a power of two, 2..4096.
- `LW`, `$clog2(DL)+1`: width of the length and index fields.
---
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `bus_addr`  in  32: byte address; only bits `[$clog2(DL)+2:0]` are decoded.
- `bus_wdata`  in  32: write data.
- `bus_wen`  in  1: write strobe, single cycle.
- `bus_ren`  in  1: read strobe, single cycle.
- `bus_rdata`  out  32: read data, valid while `bus_ack` is high.
- `bus_ack`  out  1: access acknowledge.
- `bus_err`  out  1: access error, qualified by `bus_ack`.
- `str_tdata`  out  `DW`: sample.
- `str_tlast`  out  1: last sample of the packet.
- `str_tvalid`  out  1: AXI4-stream valid.
- `str_tready`  in  1: AXI4-stream ready.

## Operation
- Address map, decoded on bit `A = $clog2(DL)+2`:
  - `A=0`: buffer, word `i` at byte address `i*4`. Writes store `wdata[DW-1:0]`. Reads return the sample sign-extended to 32 bits.
  - `A=1`, offset `0x0` CTL (write-only): bit0 start, bit1 stop. Both are write-1 pulses; reads return 0.
  - `A=1`, offset `0x4` LEN: number of samples to send. Writes are clamped to `DL`. Reset value is `DL`.
  - `A=1`, offset `0x8` STS (read-only): bit0 busy, bit1 aborted, bits `[16+:LW]` index of the next sample to be handshaken.
  - Any other register offset: `bus_ack=1`, `bus_err=1`, reads return 0.
- The buffer is a dual-port RAM. Port A serves the bus; port B serves playback. Read latency is 1 cycle on both ports.
- State machine:
  - **IDLE**: on a start write with `LEN!=0`, go to RUN. Index is set to 0 and aborted is cleared. A start with `LEN=0` is acked without error and ignored.
  - **RUN**: prefetch samples through a 2-entry output skid so that throughput is 1 sample/cycle while `str_tready=1`.
    - `str_tlast=1` on the sample at index `LEN-1`.
    - After the `tlast` handshake, go to IDLE.
- A stop write in RUN takes effect as follows:
  - No new samples are presented after the stop.
  - If `str_tvalid` is high, that beat is held until it handshakes, because a valid beat is never withdrawn. This beat is sent with `tlast=0` unless it is the true last sample.
  - The block then goes to IDLE. aborted is set to 1 unless the final sample completed normally.
- Stop in IDLE: no effect.
- Start in RUN: ignored, acked without error.
- While busy:
  - Buffer writes and LEN writes return `bus_err=1` and have no effect.
  - Buffer reads are allowed.
- LEN is sampled at start; it does not change during RUN.

## Timing
- Reset values:
  - `bus_ack`, `bus_err`, `bus_rdata`, `str_tvalid`, `str_tlast`, `str_tdata`: all 0.
  - busy=0, aborted=0, index=0, LEN=`DL`. Buffer contents are undefined.
- `bus_ack` is high for exactly 1 cycle, the cycle after `wen` or `ren`; `rdata` and `err` are valid in the same cycle. A strobe occurring one cycle later still gets its own ack.
- Start write at cycle T:
  - busy=1 at T+1.
  - First `str_tvalid=1` at T+3.
  - With `tready` held at 1, sample `k` is presented at T+3+k.
- busy falls in the cycle after the final handshake, whether it is a `tlast` or an abort beat.
- Reset mid-RUN drops `str_tvalid` in the next cycle. This is the only case where a valid beat is withdrawn.

## Test plan
- Write samples −8..7 to words 0..15, set LEN=16, start, `tready=1` → 16 consecutive beats −8..7, `tlast` only on 7, first `tvalid` 3 cycles after the start write, busy clears afterwards.
- Same packet with `tready` toggling on a pseudo-random pattern → identical data order, no duplicated or dropped beats, `tdata`/`tlast` stable while `tvalid && !tready`.
- LEN write 300 with `DL=256` → LEN reads back 256. LEN=0 then start → busy stays 0 and no beats are sent.
- Stop after 5 handshakes, with the 6th beat pending and `tready=0` → the 6th beat is held until `tready`, then no more beats, `tlast` never asserted, STS aborted=1 and index=6.
- During RUN: buffer write → `err=1` and buffer word unchanged on readback; read word 3 → ack with the sign-extended value; write to offset `0xC` → `err=1`.
- Assert `rst` mid-packet → `str_tvalid=0` in the next cycle, busy=0, LEN=256.
